credit_ledger: RTL and testbench

CREDIT_LEDGER -- requirements
Module: credit_ledger

---
 rtl/credit_ledger_if.sv | 28 ++
 rtl/credit_ledger.sv | 166 ++++++++++++++++
 tb/tb_credit_ledger.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/credit_ledger_if.sv
// Bus bundle for credit_ledger: coin/spin/win inputs, BCD display outputs and spin handshake.
interface credit_ledger_if;
    logic       coin_in;
    logic       spin_req;
    logic       win_valid;
    logic [3:0] win_bcd1;
    logic [3:0] win_bcd0;
    logic [3:0] won_amt1;
    logic [3:0] won_amt2;
    logic [3:0] credit_amt1;
    logic [3:0] credit_amt2;
    logic [3:0] credit_amt3;
    logic       spin_grant;
    logic       spin_denied;
    logic       busy;

    modport master (
        output coin_in, spin_req, win_valid, win_bcd1, win_bcd0,
        input  won_amt1, won_amt2, credit_amt1, credit_amt2, credit_amt3,
        input  spin_grant, spin_denied, busy
    );

    modport slave (
        input  coin_in, spin_req, win_valid, win_bcd1, win_bcd0,
        output won_amt1, won_amt2, credit_amt1, credit_amt2, credit_amt3,
        output spin_grant, spin_denied, busy
    );
endinterface

// File: rtl/credit_ledger.sv
// Three-digit BCD credit ledger: coins, bets and a tick-paced win payout, all saturating at 000/999.
module credit_ledger #(
    parameter logic [23:0] TICK_DIV = 24'd4_800_000
) (
    input  logic            clk,
    input  logic            reset_n,
    credit_ledger_if.slave  bus
);

    typedef enum logic {IDLE = 1'b0, PAYOUT = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [11:0] credit_q, credit_d;
    logic [7:0]  won_q, won_d;
    logic [7:0]  rem_q, rem_d;
    logic [23:0] tick_q, tick_d;
    logic        grant_q, denied_q, busy_q;
    logic        bet_s, pay_s, denied_s;
    logic [7:0]  win_clamped_s;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    function automatic logic [11:0] bcd3_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v == 12'h999) begin
            r = v;
        end else if (v[3:0] != 4'd9) begin
            r[3:0] = v[3:0] + 4'd1;
        end else if (v[7:4] != 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = v[7:4] + 4'd1;
        end else begin
            r[3:0]  = 4'd0;
            r[7:4]  = 4'd0;
            r[11:8] = v[11:8] + 4'd1;
        end
        return r;
    endfunction

    function automatic logic [11:0] bcd3_dec(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v == 12'h000) begin
            r = v;
        end else if (v[3:0] != 4'd0) begin
            r[3:0] = v[3:0] - 4'd1;
        end else if (v[7:4] != 4'd0) begin
            r[3:0] = 4'd9;
            r[7:4] = v[7:4] - 4'd1;
        end else begin
            r[3:0]  = 4'd9;
            r[7:4]  = 4'd9;
            r[11:8] = v[11:8] - 4'd1;
        end
        return r;
    endfunction

    function automatic logic [7:0] bcd2_dec(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (v == 8'h00) begin
            r = v;
        end else if (v[3:0] != 4'd0) begin
            r[3:0] = v[3:0] - 4'd1;
        end else begin
            r[3:0] = 4'd9;
            r[7:4] = v[7:4] - 4'd1;
        end
        return r;
    endfunction

    assign win_clamped_s = {bcd_clamp(bus.win_bcd1), bcd_clamp(bus.win_bcd0)};

    // Next-state, bet/payout decisions and saturating credit arithmetic.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        won_d    = won_q;
        rem_d    = rem_q;
        tick_d   = tick_q;
        bet_s    = 1'b0;
        pay_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.win_valid) begin
                    won_d = win_clamped_s;
                    rem_d = win_clamped_s;
                    if (win_clamped_s != 8'h00) begin
                        state_d = PAYOUT;
                        tick_d  = 24'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (bus.spin_req && ((credit_q != 12'h000) || bus.coin_in)) begin
                    bet_s = 1'b1;
                    won_d = 8'h00;
                end else begin
                    bet_s = 1'b0;
                end
            end
            PAYOUT: begin
                if (tick_q == (TICK_DIV - 24'd1)) begin
                    pay_s  = 1'b1;
                    tick_d = 24'd0;
                    rem_d  = bcd2_dec(rem_q);
                    if (rem_d == 8'h00) begin
                        state_d = IDLE;
                    end else begin
                        state_d = PAYOUT;
                    end
                end else begin
                    tick_d = tick_q + 24'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Net change is coin + pay - bet; each +1/-1 step saturates at the range ends.
        case ({bus.coin_in, pay_s, bet_s})
            3'b110:                 credit_d = bcd3_inc(bcd3_inc(credit_q));
            3'b100, 3'b010, 3'b111: credit_d = bcd3_inc(credit_q);
            3'b001:                 credit_d = bcd3_dec(credit_q);
            default:                credit_d = credit_q;
        endcase
    end

    assign denied_s = bus.spin_req & ~bet_s;

    // State, ledger and handshake registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            credit_q <= 12'h000;
            won_q    <= 8'h00;
            rem_q    <= 8'h00;
            tick_q   <= 24'd0;
            grant_q  <= 1'b0;
            denied_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            won_q    <= won_d;
            rem_q    <= rem_d;
            tick_q   <= tick_d;
            grant_q  <= bet_s;
            denied_q <= denied_s;
            busy_q   <= (state_d == PAYOUT);
        end
    end

    assign bus.credit_amt1 = credit_q[11:8];
    assign bus.credit_amt2 = credit_q[7:4];
    assign bus.credit_amt3 = credit_q[3:0];
    assign bus.won_amt1    = won_q[7:4];
    assign bus.won_amt2    = won_q[3:0];
    assign bus.spin_grant  = grant_q;
    assign bus.spin_denied = denied_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_credit_ledger.sv
// Directed bench for credit_ledger with TICK_DIV=4: vector table plus payout/reset sequences.
module tb_credit_ledger;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    credit_ledger_if bus();

    credit_ledger #(.TICK_DIV(24'd4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        coin;
        logic        spin;
        logic        winv;
        logic [3:0]  w1;
        logic [3:0]  w0;
        logic [11:0] e_credit;
        logic [7:0]  e_won;
        logic        e_grant;
        logic        e_denied;
        logic        e_busy;
    } vec_t;

    vec_t tbl[17];

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        r[11:8] = 4'((v / 100) % 10);
        r[7:4]  = 4'((v / 10) % 10);
        r[3:0]  = 4'(v % 10);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input logic [11:0] ec, input logic [7:0] ew,
                           input logic eg, input logic ed, input logic eb);
        chk({name, ".credit"}, {20'd0, bus.credit_amt1, bus.credit_amt2, bus.credit_amt3}, {20'd0, ec});
        chk({name, ".won"},    {24'd0, bus.won_amt1, bus.won_amt2}, {24'd0, ew});
        chk({name, ".grant"},  {31'd0, bus.spin_grant},  {31'd0, eg});
        chk({name, ".denied"}, {31'd0, bus.spin_denied}, {31'd0, ed});
        chk({name, ".busy"},   {31'd0, bus.busy},        {31'd0, eb});
    endtask

    task automatic cyc(input logic c, input logic s, input logic w,
                       input logic [3:0] b1, input logic [3:0] b0);
        @(negedge clk);
        bus.coin_in   = c;
        bus.spin_req  = s;
        bus.win_valid = w;
        bus.win_bcd1  = b1;
        bus.win_bcd0  = b0;
        @(posedge clk);
        #1;
        bus.coin_in   = 1'b0;
        bus.spin_req  = 1'b0;
        bus.win_valid = 1'b0;
        bus.win_bcd1  = 4'd0;
        bus.win_bcd0  = 4'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #3;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int ec;
        int rem;
        checks        = 0;
        errors        = 0;
        reset_n       = 1'b0;
        bus.coin_in   = 1'b0;
        bus.spin_req  = 1'b0;
        bus.win_valid = 1'b0;
        bus.win_bcd1  = 4'd0;
        bus.win_bcd0  = 4'd0;

        // coin, spin, winv, w1, w0, credit, won, grant, denied, busy
        for (int i = 0; i < 12; i++)
            tbl[i] = '{1'b1, 1'b0, 1'b0, 4'd0, 4'd0, to_bcd(i + 1), 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 12'h011, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 12'h011, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 12'h011, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 12'h011, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 12'h010, 8'h00, 1'b1, 1'b0, 1'b0};

        #12;
        chk_all("reset_async", 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        chk_all("reset_state", 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].coin, tbl[i].spin, tbl[i].winv, tbl[i].w1, tbl[i].w0);
            chk_all($sformatf("vec%0d", i), tbl[i].e_credit, tbl[i].e_won,
                    tbl[i].e_grant, tbl[i].e_denied, tbl[i].e_busy);
        end

        // Grant from 001, then denial at 000.
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        chk_all("grant_001", 12'h000, 8'h00, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        chk_all("grant_drop", 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        chk_all("deny_000", 12'h000, 8'h00, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        chk_all("deny_drop", 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);

        // Payout of 15 from 098, with a spin and a second win ignored mid-payout.
        do_reset();
        for (int i = 0; i < 98; i++) cyc(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        cyc(1'b0, 1'b0, 1'b1, 4'd1, 4'd5);
        chk_all("win15_entry", 12'h098, 8'h15, 1'b0, 1'b0, 1'b1);
        ec  = 98;
        rem = 15;
        for (int n = 1; n <= 60; n++) begin
            if (n == 9) cyc(1'b0, 1'b0, 1'b1, 4'd9, 4'd9);
            else        cyc(1'b0, (n == 6), 1'b0, 4'd0, 4'd0);
            if (n % 4 == 0) begin
                ec++;
                rem--;
            end
            chk_all($sformatf("pay15_n%0d", n), to_bcd(ec), 8'h15, 1'b0, (n == 6), (rem != 0));
        end
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        chk_all("pay15_after", 12'h113, 8'h15, 1'b0, 1'b0, 1'b0);

        // Payout from 998 with coins every cycle: saturates, still terminates after 5 ticks.
        do_reset();
        for (int i = 0; i < 998; i++) cyc(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        cyc(1'b0, 1'b0, 1'b1, 4'd0, 4'd5);
        chk_all("win5_entry", 12'h998, 8'h05, 1'b0, 1'b0, 1'b1);
        ec  = 998;
        rem = 5;
        for (int n = 1; n <= 20; n++) begin
            cyc(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
            ec = ec + 1;
            if (n % 4 == 0) begin
                ec++;
                rem--;
            end
            if (ec > 999) ec = 999;
            chk_all($sformatf("sat_n%0d", n), to_bcd(ec), 8'h05, 1'b0, 1'b0, (rem != 0));
        end
        cyc(1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
        chk_all("bet_at_999", 12'h999, 8'h00, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        chk_all("bet_from_999", 12'h998, 8'h00, 1'b1, 1'b0, 1'b0);

        // Coin and spin together at 000, after a win so won must clear.
        do_reset();
        cyc(1'b0, 1'b0, 1'b1, 4'd0, 4'd1);
        chk_all("win1_entry", 12'h000, 8'h01, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        chk_all("spin_in_payout", 12'h000, 8'h01, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        chk_all("win1_done", 12'h001, 8'h01, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        chk_all("spend_to_000", 12'h000, 8'h00, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
        chk_all("coin_bet_000", 12'h000, 8'h00, 1'b1, 1'b0, 1'b0);

        // Win digits above 9 clamp to 9.
        do_reset();
        cyc(1'b0, 1'b0, 1'b1, 4'hF, 4'hA);
        chk_all("clamp_entry", 12'h000, 8'h99, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 4; n++) cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        chk_all("clamp_tick", 12'h001, 8'h99, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a payout of 07.
        do_reset();
        cyc(1'b0, 1'b0, 1'b1, 4'd0, 4'd7);
        chk_all("win7_entry", 12'h000, 8'h07, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 5; n++) cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        chk_all("win7_one_tick", 12'h001, 8'h07, 1'b0, 1'b0, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all("mid_reset", 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int n = 0; n < 12; n++) begin
            cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
            chk_all($sformatf("post_reset_n%0d", n), 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
